// File: rtl/ysyx_22050243_if_id_reg.sv
// IF->ID pipeline register with a one-entry skid buffer, stall hold and flush.
// Optional perf counters (stall_cycles, flush_count) under YSYX_22050243_IFID_PERF_EN.
module ysyx_22050243_if_id_reg #(
  parameter int unsigned             PC_WIDTH       = 64,
  parameter int unsigned             INST_WIDTH     = 32,
  parameter int unsigned             GPR_ADDR_WIDTH = 5,
  parameter logic [INST_WIDTH-1:0]   NOP_INST       = INST_WIDTH'(32'h00000013)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_WIDTH-1:0]       in_pc,
  input  logic [INST_WIDTH-1:0]     in_inst,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [INST_WIDTH-1:0]     out_inst,
  output logic [GPR_ADDR_WIDTH-1:0] rs1_if_2_id_ff,
  output logic [GPR_ADDR_WIDTH-1:0] rs2_if_2_id_ff
`ifdef YSYX_22050243_IFID_PERF_EN
  ,
  output logic [63:0]               stall_cycles,
  output logic [63:0]               flush_count
`endif
);

  logic                      m_valid_q, m_valid_d;
  logic [PC_WIDTH-1:0]       m_pc_q, m_pc_d;
  logic [INST_WIDTH-1:0]     m_inst_q, m_inst_d;
  logic                      s_valid_q, s_valid_d;
  logic [PC_WIDTH-1:0]       s_pc_q, s_pc_d;
  logic [INST_WIDTH-1:0]     s_inst_q, s_inst_d;
  logic                      in_ready_q, in_ready_d;
  logic [GPR_ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [GPR_ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic                      accept;
  logic                      advance;

  // Next-state: flush beats advance beats hold.
  always_comb begin
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_inst_d  = m_inst_q;
    s_valid_d = s_valid_q;
    s_pc_d    = s_pc_q;
    s_inst_d  = s_inst_q;
    accept    = in_valid && !s_valid_q;
    advance   = !m_valid_q || !stall;

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_inst_d  = NOP_INST;
    end else if (advance) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_pc_d    = s_pc_q;
        m_inst_d  = s_inst_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_pc_d    = in_pc;
        m_inst_d  = in_inst;
      end else begin
        m_valid_d = 1'b0;
        m_inst_d  = NOP_INST;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_pc_d    = in_pc;
      s_inst_d  = in_inst;
    end

    // Side outputs are registered alongside M so they change on the same edge.
    in_ready_d = !s_valid_d;
    rs1_d      = m_valid_d ? GPR_ADDR_WIDTH'(m_inst_d[19:15]) : '0;
    rs2_d      = m_valid_d ? GPR_ADDR_WIDTH'(m_inst_d[24:20]) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      m_pc_q     <= '0;
      m_inst_q   <= NOP_INST;
      s_valid_q  <= 1'b0;
      s_pc_q     <= '0;
      s_inst_q   <= NOP_INST;
      in_ready_q <= 1'b1;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else begin
      m_valid_q  <= m_valid_d;
      m_pc_q     <= m_pc_d;
      m_inst_q   <= m_inst_d;
      s_valid_q  <= s_valid_d;
      s_pc_q     <= s_pc_d;
      s_inst_q   <= s_inst_d;
      in_ready_q <= in_ready_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = m_valid_q;
  assign out_pc         = m_pc_q;
  assign out_inst       = m_inst_q;
  assign rs1_if_2_id_ff = rs1_q;
  assign rs2_if_2_id_ff = rs2_q;

`ifdef YSYX_22050243_IFID_PERF_EN
  logic [63:0] stall_cycles_q, stall_cycles_d;
  logic [63:0] flush_count_q, flush_count_d;

  // Free-running event counters, wrapping naturally at 2^64.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (m_valid_q && stall && !flush) stall_cycles_d = stall_cycles_q + 64'd1;
    if (flush)                        flush_count_d  = flush_count_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: doc/ysyx_22050243_if_id_reg.md
Name: ysyx_22050243_if_id_reg

Overview:
IF->ID pipeline register for the 5-stage RV64 core. It sits directly upstream of the load-use/CSR hazard detector.
- Accepts fetched (pc, inst) from IF with a valid/ready handshake.
- Holds them stable while the detector's stall is high, using a one-entry skid buffer so an in-flight fetch response is never dropped.
- Drops both entries on a branch/exception flush.
- Drives the rs1_if_2_id_ff / rs2_if_2_id_ff fields the detector consumes.

Parameters:
- PC_WIDTH, 64, width of the program counter.
- INST_WIDTH, 32, instruction width.
- GPR_ADDR_WIDTH, 5, register-index width of the rs1/rs2 outputs.
- NOP_INST, 32'h00000013, bubble encoding (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  IF presents a fetched instruction.
- in_ready  output  1  register can accept (in_valid && in_ready = transfer).
- in_pc  input  PC_WIDTH  PC of fetched instruction.
- in_inst  input  INST_WIDTH  fetched instruction word.
- stall  input  1  from hazard detector; ID must not consume this cycle.
- flush  input  1  from EX redirect/trap; kill all held instructions.
- out_valid  output  1  ID stage holds a live instruction.
- out_pc  output  PC_WIDTH  PC to ID.
- out_inst  output  INST_WIDTH  instruction to ID; NOP_INST when not valid.
- rs1_if_2_id_ff  output  GPR_ADDR_WIDTH  out_inst[19:15], 0 when !out_valid.
- rs2_if_2_id_ff  output  GPR_ADDR_WIDTH  out_inst[24:20], 0 when !out_valid.

Behaviour:
- State:
  - main entry M = {m_valid, m_pc, m_inst}, drives out_* directly (registered outputs).
  - skid entry S = {s_valid, s_pc, s_inst}.
- Reset (async, rst_n low): m_valid=s_valid=0, m_pc=s_pc=0, m_inst=s_inst=NOP_INST. Consequently out_valid=0, out_pc=0, out_inst=NOP_INST, rs1/rs2=0, in_ready=1. Reset mid-transfer discards everything; no partial state survives.
- in_ready = !s_valid. It is combinational from state only and never depends on in_valid, stall or flush.
- accept = in_valid && in_ready. advance = !m_valid || !stall.
- Invariant: s_valid implies m_valid. The bench asserts this every cycle.
- Priority per edge: flush > advance > hold.
- flush=1: m_valid=0, s_valid=0, m_inst=NOP_INST. Any instruction accepted in the same cycle is discarded. Flush wins over stall.
- advance, no flush:
  - if s_valid: M<=S, s_valid<=0; an accept this cycle is impossible (in_ready=0).
  - else if accept: M<={1,in_pc,in_inst}.
  - else: m_valid<=0, m_inst<=NOP_INST.
- Hold (m_valid && stall), no flush:
  - M unchanged.
  - if accept: S<={1,in_pc,in_inst}.
  - S already full: in_ready=0, so no accept occurs.
- Latency: accepted instruction appears on out_* the next cycle when not stalled. After a stall releases, the skid entry appears one cycle later. Zero bubbles are inserted by the skid path.
- Throughput: 1 instr/cycle when stall=0.
- Ordering: instructions leave in acceptance order; no duplication, no loss except on flush.
- Stall with m_valid=0 has no effect; advance is true.
- pc/inst of an invalid entry are don't-care, except that out_inst must equal NOP_INST whenever out_valid=0.

Optional Feature:
- Macro: YSYX_22050243_IFID_PERF_EN.
- Defined: adds output ports stall_cycles[63:0] and flush_count[63:0].
  - stall_cycles increments on each cycle with m_valid && stall && !flush.
  - flush_count increments on each cycle with flush=1.
  - Both reset to 0 asynchronously and wrap modulo 2^64.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_inst=0x00000013, rs1/rs2=0, in_ready=1. Release -> first accepted instr visible next cycle.
- Streaming: pc 0x80000000,+4,+8 with in_valid=1, stall=0 -> out_pc follows one cycle later each cycle. Instruction 0x00B50533 gives rs1=10, rs2=11.
- Stall with skid:
  - M=pc 0x80000000; assert stall 3 cycles while IF offers 0x80000004 then 0x80000008.
  - Required: 0x80000004 captured in S, in_ready=0 thereafter, 0x80000008 held at IF, out_pc stays 0x80000000.
  - Release: 0x80000004 then 0x80000008 on consecutive cycles.
- Flush over stall: M and S full, stall=1, flush=1, in_valid=0 -> next cycle out_valid=0, out_inst=NOP, in_ready=1. Next accepted pc 0x80001000 appears one cycle after.
- Flush with simultaneous accept: flush=1 and in_valid=1 (in_ready=1), pc 0x80000010 -> instruction discarded, out_valid=0 next cycle.
- Async reset mid-stall: assert rst_n=0 between edges with S full -> outputs reach reset values immediately without a clock edge. With the macro defined, both counters read 0.
